// File: rtl/video_timing_gen.sv
// Combined horizontal/vertical video timing generator with programmable porches and resolution.
// Staged configuration is committed at a frame boundary, or right away while the counters are idle.
module video_timing_gen #(
  parameter int CNT_WIDTH = 11,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int H_RES_D   = 640,
  parameter int H_FP_D    = 16,
  parameter int H_SYNC_D  = 96,
  parameter int H_BP_D    = 48,
  parameter int V_RES_D   = 480,
  parameter int V_FP_D    = 10,
  parameter int V_SYNC_D  = 2,
  parameter int V_BP_D    = 33
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [1:0]                  step_sel,
  input  logic                        cfg_we,
  input  logic [2:0]                  cfg_addr,
  input  logic [CNT_WIDTH-2:0]        cfg_data,
  input  logic                        cfg_commit,
  output logic                        cfg_pending,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        hblank,
  output logic                        vblank,
  output logic                        blank,
  output logic signed [CNT_WIDTH-1:0] x,
  output logic signed [CNT_WIDTH-1:0] y,
  output logic                        line_end,
  output logic                        frame_end
);

  localparam int unsigned FW = CNT_WIDTH - 1;
  localparam int unsigned WW = CNT_WIDTH + 1;

  localparam int H_HT_D = H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_HT_D = V_FP_D + V_SYNC_D + V_BP_D;

  // Register file layout matches cfg_addr: 0..3 horizontal, 4..7 vertical.
  localparam logic [7:0][FW-1:0] CFG_D = {
    FW'(V_BP_D), FW'(V_SYNC_D), FW'(V_FP_D), FW'(V_RES_D),
    FW'(H_BP_D), FW'(H_SYNC_D), FW'(H_FP_D), FW'(H_RES_D)
  };

  localparam logic [2:0] A_H_RES  = 3'd0;
  localparam logic [2:0] A_H_FP   = 3'd1;
  localparam logic [2:0] A_H_SYNC = 3'd2;
  localparam logic [2:0] A_H_BP   = 3'd3;
  localparam logic [2:0] A_V_RES  = 3'd4;
  localparam logic [2:0] A_V_FP   = 3'd5;
  localparam logic [2:0] A_V_SYNC = 3'd6;
  localparam logic [2:0] A_V_BP   = 3'd7;

  function automatic logic signed [WW-1:0] ext(input logic [FW-1:0] v);
    return signed'({{(WW-FW){1'b0}}, v});
  endfunction

  logic [7:0][FW-1:0]          stg_q;
  logic [7:0][FW-1:0]          stg_d;
  logic [7:0][FW-1:0]          act_q;
  logic [7:0][FW-1:0]          act_d;
  logic signed [WW-1:0]        step_w;
  logic signed [WW-1:0]        x_w;
  logic signed [WW-1:0]        y_w;
  logic signed [WW-1:0]        x_sum;
  logic signed [WW-1:0]        h_ht;
  logic signed [WW-1:0]        v_ht;
  logic signed [WW-1:0]        new_h_ht;
  logic signed [WW-1:0]        new_v_ht;
  logic signed [CNT_WIDTH-1:0] x_d;
  logic signed [CNT_WIDTH-1:0] y_d;
  logic                        apply;
  logic                        pending_d;
  logic                        hs_in;
  logic                        vs_in;

  // Staging contents as seen at the next edge; a same-cycle write joins a commit.
  always_comb begin
    stg_d = stg_q;
    if (cfg_we) begin
      stg_d[cfg_addr] = cfg_data;
    end
  end

  // Counter advance, wrap strobes and configuration apply.
  always_comb begin
    case (step_sel)
      2'b00:   step_w = WW'(1);
      2'b01:   step_w = WW'(2);
      default: step_w = WW'(4);
    endcase

    x_w      = WW'(x);
    y_w      = WW'(y);
    x_sum    = x_w + step_w;
    h_ht     = ext(act_q[A_H_FP]) + ext(act_q[A_H_SYNC]) + ext(act_q[A_H_BP]);
    v_ht     = ext(act_q[A_V_FP]) + ext(act_q[A_V_SYNC]) + ext(act_q[A_V_BP]);
    new_h_ht = ext(stg_d[A_H_FP]) + ext(stg_d[A_H_SYNC]) + ext(stg_d[A_H_BP]);
    new_v_ht = ext(stg_d[A_V_FP]) + ext(stg_d[A_V_SYNC]) + ext(stg_d[A_V_BP]);

    line_end  = enable && (x_sum >= ext(act_q[A_H_RES]));
    frame_end = line_end && (y_w >= (ext(act_q[A_V_RES]) - WW'(1)));
    apply     = (cfg_pending || cfg_commit) && (frame_end || !enable);

    x_d       = x;
    y_d       = y;
    act_d     = act_q;
    pending_d = cfg_pending;

    if (apply) begin
      act_d     = stg_d;
      pending_d = 1'b0;
      x_d       = CNT_WIDTH'(-new_h_ht);
      y_d       = CNT_WIDTH'(-new_v_ht);
    end else begin
      if (cfg_commit) begin
        pending_d = 1'b1;
      end
      if (enable) begin
        if (line_end) begin
          x_d = CNT_WIDTH'(-h_ht);
          y_d = frame_end ? CNT_WIDTH'(-v_ht) : CNT_WIDTH'(y_w + WW'(1));
        end else begin
          x_d = CNT_WIDTH'(x_sum);
        end
      end
    end
  end

  // Sync windows: -(SYNC+BP) <= cnt < -BP.
  always_comb begin
    hs_in = (x_w >= -(ext(act_q[A_H_SYNC]) + ext(act_q[A_H_BP]))) && (x_w < -ext(act_q[A_H_BP]));
    vs_in = (y_w >= -(ext(act_q[A_V_SYNC]) + ext(act_q[A_V_BP]))) && (y_w < -ext(act_q[A_V_BP]));
  end

  assign hsync  = (HSYNC_POL != 0) ? hs_in : !hs_in;
  assign vsync  = (VSYNC_POL != 0) ? vs_in : !vs_in;
  assign hblank = x[CNT_WIDTH-1];
  assign vblank = y[CNT_WIDTH-1];
  assign blank  = hblank | vblank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_q       <= CFG_D;
      act_q       <= CFG_D;
      x           <= CNT_WIDTH'(-H_HT_D);
      y           <= CNT_WIDTH'(-V_HT_D);
      cfg_pending <= 1'b0;
    end else begin
      stg_q       <= stg_d;
      act_q       <= act_d;
      x           <= x_d;
      y           <= y_d;
      cfg_pending <= pending_d;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: fixed vector table, directed corner sequences and
// randomized traffic, all compared every cycle against an integer reference model.
module tb_video_timing_gen;

  localparam int CW = 11;
  localparam int FW = CW - 1;

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic [1:0]           step_sel;
  logic                 cfg_we;
  logic [2:0]           cfg_addr;
  logic [FW-1:0]        cfg_data;
  logic                 cfg_commit;
  logic                 cfg_pending;
  logic                 hsync;
  logic                 vsync;
  logic                 hblank;
  logic                 vblank;
  logic                 blank;
  logic signed [CW-1:0] x;
  logic signed [CW-1:0] y;
  logic                 line_end;
  logic                 frame_end;

  video_timing_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .step_sel(step_sel),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending), .hsync(hsync), .vsync(vsync), .hblank(hblank),
    .vblank(vblank), .blank(blank), .x(x), .y(y), .line_end(line_end), .frame_end(frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_checks;

  // Reference model: config registers as plain integers plus current screen position.
  int act [8];
  int stg [8];
  int mx;
  int my;
  bit mp;

  typedef struct {
    bit         en;
    logic [1:0] ss;
    bit         we;
    logic [2:0] a;
    int         d;
    bit         cm;
    int         ex;
    int         ey;
    bit         ep;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic signed [31:0] g, input logic signed [31:0] e);
    n_checks++;
    if (g === e) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, g, g, e, e);
  endtask

  function automatic int step_of(input logic [1:0] ss);
    return (ss == 2'd0) ? 1 : (ss == 2'd1) ? 2 : 4;
  endfunction

  task automatic model_reset();
    act = '{640, 16, 96, 48, 480, 10, 2, 33};
    stg = act;
    mx  = -160;
    my  = -45;
    mp  = 1'b0;
  endtask

  task automatic check_model(input bit en_i, input logic [1:0] ss_i);
    bit le, fe, hs, vs;
    logic [29:0] e, g;
    le = en_i && (mx + step_of(ss_i) >= act[0]);
    fe = le && (my >= act[4] - 1);
    hs = !((mx >= -(act[2] + act[3])) && (mx < -act[3]));
    vs = !((my >= -(act[6] + act[7])) && (my < -act[7]));
    e  = {mp, hs, vs, mx < 0, my < 0, (mx < 0) || (my < 0), le, fe, CW'(mx), CW'(my)};
    g  = {cfg_pending, hsync, vsync, hblank, vblank, blank, line_end, frame_end, x, y};
    chk("outputs", 32'(g), 32'(e));
  endtask

  task automatic model_step(input bit en_i, input logic [1:0] ss_i, input bit we_i,
                            input logic [2:0] a_i, input int d_i, input bit cm_i);
    int hht;
    bit le, fe;
    hht = act[1] + act[2] + act[3];
    le  = en_i && (mx + step_of(ss_i) >= act[0]);
    fe  = le && (my >= act[4] - 1);
    if (we_i) stg[a_i] = d_i;
    if ((mp || cm_i) && (fe || !en_i)) begin
      act = stg;
      mx  = -(act[1] + act[2] + act[3]);
      my  = -(act[5] + act[6] + act[7]);
      mp  = 1'b0;
    end else begin
      if (cm_i) mp = 1'b1;
      if (en_i) begin
        if (le) begin
          mx = -hht;
          if (fe) my = -(act[5] + act[6] + act[7]);
          else my = my + 1;
        end else begin
          mx = mx + step_of(ss_i);
        end
      end
    end
  endtask

  // One clock: drive inputs, compare pre-edge outputs, advance the model.
  task automatic cyc(input bit en_i, input logic [1:0] ss_i, input bit we_i,
                     input logic [2:0] a_i, input int d_i, input bit cm_i);
    @(negedge clk);
    enable     = en_i;
    step_sel   = ss_i;
    cfg_we     = we_i;
    cfg_addr   = a_i;
    cfg_data   = FW'(d_i);
    cfg_commit = cm_i;
    #1;
    check_model(en_i, ss_i);
    model_step(en_i, ss_i, we_i, a_i, d_i, cm_i);
  endtask

  task automatic idle_inputs();
    enable = 1'b0; step_sel = 2'd0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = '0; cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    check_model(1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first, second, fe_idx, prev_le, j_le;
    bit found;
    n_pass   = 0;
    n_checks = 0;
    idle_inputs();
    reset = 1'b1;
    model_reset();

    tbl[0]  = '{1'b1, 2'd0, 1'b0, 3'd0, 0,  1'b0, -160, -45, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 3'd0, 0,  1'b0, -159, -45, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 3'd0, 0,  1'b0, -157, -45, 1'b0};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 3'd0, 0,  1'b0, -153, -45, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 3'd3, 40, 1'b0, -153, -45, 1'b0};
    tbl[5]  = '{1'b1, 2'd3, 1'b0, 3'd0, 0,  1'b0, -153, -45, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 3'd0, 0,  1'b1, -149, -45, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 3'd0, 0,  1'b0, -148, -45, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 3'd0, 0,  1'b0, -147, -45, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 3'd0, 0,  1'b0, -152, -45, 1'b0};
    tbl[10] = '{1'b1, 2'd0, 1'b0, 3'd0, 0,  1'b0, -152, -45, 1'b0};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 3'd0, 0,  1'b0, -151, -45, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_model(1'b0, 2'd0);
    chk("rst_x", 32'(x), 32'(-160));
    chk("rst_y", 32'(y), 32'(-45));
    chk("rst_flags", 32'({cfg_pending, hsync, vsync, hblank, vblank, blank, line_end, frame_end}),
        32'(8'b0111_1100));
    @(negedge clk);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].en, tbl[i].ss, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].cm);
      chk("tbl_x", 32'(x), 32'(tbl[i].ex));
      chk("tbl_y", 32'(y), 32'(tbl[i].ey));
      chk("tbl_pend", 32'(cfg_pending), 32'(tbl[i].ep));
    end

    // Default timing, step 1: 800-clock lines and hsync window edges
    do_reset();
    first = -1; second = -1;
    for (int i = 0; i < 1600; i++) begin
      cyc(1'b1, 2'd0, 1'b0, 3'd0, 0, 1'b0);
      if (i == 15)  chk("hsync_x-145", 32'(hsync), 32'(1));
      if (i == 16)  chk("hsync_x-144", 32'(hsync), 32'(0));
      if (i == 111) chk("hsync_x-49", 32'(hsync), 32'(0));
      if (i == 112) chk("hsync_x-48", 32'(hsync), 32'(1));
      if (line_end) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("le_first_step1", first, 799);
    chk("le_period_step1", second - first, 800);

    // Step 4: 200-clock lines, x wraps 636 -> -160
    do_reset();
    first = -1; second = -1;
    for (int i = 0; i < 400; i++) begin
      cyc(1'b1, 2'd2, 1'b0, 3'd0, 0, 1'b0);
      if (i == 1)   chk("step4_x1", 32'(x), 32'(-156));
      if (i == 199) chk("step4_x_last", 32'(x), 32'(636));
      if (i == 200) chk("step4_x_wrap", 32'(x), 32'(-160));
      if (line_end) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("le_first_step4", first, 199);
    chk("le_period_step4", second - first, 200);

    // Idle commit in the same cycle as the write
    do_reset();
    cyc(1'b0, 2'd0, 1'b1, 3'd4, 240, 1'b1);
    cyc(1'b0, 2'd0, 1'b0, 3'd0, 0, 1'b0);
    chk("idle_apply_y", 32'(y), 32'(-45));
    chk("idle_apply_x", 32'(x), 32'(-160));
    chk("idle_apply_pend", 32'(cfg_pending), 32'(0));

    // Short frame, then mid-frame H commit applied only at frame_end
    do_reset();
    cyc(1'b0, 2'd0, 1'b1, 3'd4, 4, 1'b0);
    cyc(1'b0, 2'd0, 1'b1, 3'd5, 1, 1'b0);
    cyc(1'b0, 2'd0, 1'b1, 3'd6, 1, 1'b0);
    cyc(1'b0, 2'd0, 1'b1, 3'd7, 1, 1'b1);
    cyc(1'b0, 2'd0, 1'b0, 3'd0, 0, 1'b0);
    chk("small_v_y", 32'(y), 32'(-3));
    for (int i = 0; i < 300; i++) cyc(1'b1, 2'd2, 1'b0, 3'd0, 0, 1'b0);
    cyc(1'b1, 2'd2, 1'b1, 3'd0, 320, 1'b0);
    cyc(1'b1, 2'd2, 1'b1, 3'd1, 8, 1'b0);
    cyc(1'b1, 2'd2, 1'b1, 3'd2, 48, 1'b0);
    cyc(1'b1, 2'd2, 1'b1, 3'd3, 24, 1'b1);
    found = 1'b0; fe_idx = -1; prev_le = -1;
    for (int i = 0; i < 3000 && !found; i++) begin
      cyc(1'b1, 2'd2, 1'b0, 3'd0, 0, 1'b0);
      if (i == 0) chk("pend_set", 32'(cfg_pending), 32'(1));
      if (frame_end) begin
        found  = 1'b1;
        fe_idx = i;
        chk("pend_at_fe", 32'(cfg_pending), 32'(1));
      end else if (line_end) begin
        prev_le = i;
      end
    end
    chk("fe_seen", 32'(found), 32'(1));
    chk("old_line_period", fe_idx - prev_le, 200);
    j_le = -1;
    for (int j = 0; j < 300 && j_le < 0; j++) begin
      cyc(1'b1, 2'd2, 1'b0, 3'd0, 0, 1'b0);
      if (j == 0) begin
        chk("reload_new_ht", 32'(x), 32'(-80));
        chk("pend_cleared", 32'(cfg_pending), 32'(0));
      end
      if (line_end) j_le = j;
    end
    chk("new_line_period", j_le, 99);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
          3'($urandom_range(0, 7)), int'($urandom_range(1, 100)), ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset mid-line with a commit pending
    do_reset();
    cyc(1'b1, 2'd0, 1'b0, 3'd0, 0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'd0, 1'b1, 3'd0, 100, 1'b0);
    chk("pend_before_rst", 32'(cfg_pending), 32'(1));
    @(negedge clk);
    idle_inputs();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_x", 32'(x), 32'(-160));
    chk("async_rst_y", 32'(y), 32'(-45));
    chk("async_rst_pend", 32'(cfg_pending), 32'(0));
    check_model(1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    first = -1;
    for (int i = 0; i < 800; i++) begin
      cyc(1'b1, 2'd0, 1'b0, 3'd0, 0, 1'b0);
      if (line_end && first < 0) first = i;
    end
    chk("defaults_after_rst", first, 799);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
